// File: rtl/riscv_defines.sv
// Shared RV32I decode constants for the hazard pipe and the forwarding unit.
package riscv_defines;

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_I      = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int unsigned OPC_MSB = 6;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  function automatic logic [6:0] opc_of(input logic [31:0] inst);
    return inst[OPC_MSB:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/riscv_hazard_detect.sv
// Combinational load-use compare between the ID and EX stage instructions.
module riscv_hazard_detect
  import riscv_defines::*;
(
  input  logic [31:0] inst_s2,
  input  logic [31:0] inst_s3,
  output logic        load_use_stall
);

  logic       uses_rs1;
  logic       uses_rs2;
  logic [4:0] load_rd;
  logic       unused_bits;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opc_of(inst_s2))
      OPC_R, OPC_STORE, OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_I, OPC_LOAD: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_rd = rd_of(inst_s3);

  // x0 as destination never creates a real dependency
  assign load_use_stall = (opc_of(inst_s3) == OPC_LOAD) && (load_rd != '0) &&
                          ((uses_rs1 && (load_rd == rs1_of(inst_s2))) ||
                           (uses_rs2 && (load_rd == rs2_of(inst_s2))));

  assign unused_bits = ^{inst_s2, inst_s3};

endmodule

// File: rtl/riscv_hazard_pipe.sv
// Instruction-tracking stage registers with load-use bubbles, flush, freeze and perf counters.
module riscv_hazard_pipe
  import riscv_defines::*;
#(
  parameter logic [31:0] NOP_INST = RV_NOP,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_s1,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [31:0]      inst_s2,
  output logic [31:0]      inst_s3,
  output logic [31:0]      inst_s4,
  output logic [31:0]      inst_s5,
  output logic             pc_we,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0]      inst_s2_q, inst_s2_d;
  logic [31:0]      inst_s3_q, inst_s3_d;
  logic [31:0]      inst_s4_q, inst_s4_d;
  logic [31:0]      inst_s5_q, inst_s5_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  riscv_hazard_detect u_hazard_detect (
    .inst_s2        (inst_s2_q),
    .inst_s3        (inst_s3_q),
    .load_use_stall (load_use_stall)
  );

  always_comb begin
    inst_s2_d   = inst_s2_q;
    inst_s3_d   = inst_s3_q;
    inst_s4_d   = inst_s4_q;
    inst_s5_d   = inst_s5_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_stall) begin
      // flush discards any coincident load-use bubble
      if (flush) begin
        inst_s2_d = NOP_INST;
        inst_s3_d = NOP_INST;
        inst_s4_d = inst_s3_q;
        inst_s5_d = inst_s4_q;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (load_use_stall) begin
        inst_s3_d = NOP_INST;
        inst_s4_d = inst_s3_q;
        inst_s5_d = inst_s4_q;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        inst_s2_d = inst_s1;
        inst_s3_d = inst_s2_q;
        inst_s4_d = inst_s3_q;
        inst_s5_d = inst_s4_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_s2_q   <= NOP_INST;
      inst_s3_q   <= NOP_INST;
      inst_s4_q   <= NOP_INST;
      inst_s5_q   <= NOP_INST;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      inst_s2_q   <= inst_s2_d;
      inst_s3_q   <= inst_s3_d;
      inst_s4_q   <= inst_s4_d;
      inst_s5_q   <= inst_s5_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign inst_s2   = inst_s2_q;
  assign inst_s3   = inst_s3_q;
  assign inst_s4   = inst_s4_q;
  assign inst_s5   = inst_s5_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign pc_we     = ~mem_stall & (flush | ~load_use_stall);

endmodule

// File: tb/tb_riscv_hazard_pipe.sv
// Randomized bench for riscv_hazard_pipe against an array-based pipeline reference model.
module tb_riscv_hazard_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_s1 = 32'h0;
  logic        flush = 1'b0;
  logic        mem_stall = 1'b0;

  logic [31:0] inst_s2, inst_s3, inst_s4, inst_s5;
  logic        pc_we, load_use_stall;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] n_s2, n_s3, n_s4, n_s5;
  logic        n_pc_we, n_lus;
  logic [1:0]  n_stall_cnt, n_flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m [2:5];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  riscv_hazard_pipe dut (
    .clk(clk), .rst_n(rst_n), .inst_s1(inst_s1), .flush(flush), .mem_stall(mem_stall),
    .inst_s2(inst_s2), .inst_s3(inst_s3), .inst_s4(inst_s4), .inst_s5(inst_s5),
    .pc_we(pc_we), .load_use_stall(load_use_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  riscv_hazard_pipe #(.CNT_W(2)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .inst_s1(inst_s1), .flush(flush), .mem_stall(mem_stall),
    .inst_s2(n_s2), .inst_s3(n_s3), .inst_s4(n_s4), .inst_s5(n_s5),
    .pc_we(n_pc_we), .load_use_stall(n_lus),
    .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic bit reads_rs1(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit reads_rs2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  function automatic bit model_hazard();
    logic [31:0] ex;
    logic [31:0] id;
    ex = m[3];
    id = m[2];
    if (ex[6:0] != 7'b0000011 || ex[11:7] == 5'd0) return 1'b0;
    return (reads_rs1(id) && ex[11:7] == id[19:15]) || (reads_rs2(id) && ex[11:7] == id[24:20]);
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int unsigned max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    for (int i = 2; i <= 5; i++) m[i] = NOP;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_step();
    bit hz;
    hz = model_hazard();
    if (mem_stall) return;
    m[5] = m[4];
    m[4] = m[3];
    if (flush) begin
      m[3] = NOP;
      m[2] = NOP;
      m_flush++;
    end else if (hz) begin
      m[3] = NOP;
      m_stall++;
    end else begin
      m[3] = m[2];
      m[2] = inst_s1;
    end
  endtask

  task automatic compare_all();
    bit hz;
    hz = model_hazard();
    check_eq("inst_s2", inst_s2, m[2]);
    check_eq("inst_s3", inst_s3, m[3]);
    check_eq("inst_s4", inst_s4, m[4]);
    check_eq("inst_s5", inst_s5, m[5]);
    check_eq("load_use_stall", 32'(load_use_stall), 32'(hz));
    check_eq("pc_we", 32'(pc_we), 32'(!mem_stall && (flush || !hz)));
    check_eq("stall_cnt", 32'(stall_cnt), sat(m_stall, 16'hFFFF));
    check_eq("flush_cnt", 32'(flush_cnt), sat(m_flush, 16'hFFFF));
    check_eq("stall_cnt_w2", 32'(n_stall_cnt), sat(m_stall, 3));
    check_eq("flush_cnt_w2", 32'(n_flush_cnt), sat(m_flush, 3));
  endtask

  task automatic cycle(input logic [31:0] inst, input logic fl, input logic ms);
    inst_s1   = inst;
    flush     = fl;
    mem_stall = ms;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_cycle(input logic [31:0] inst);
    inst_s1   = inst;
    flush     = 1'b0;
    mem_stall = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rd;
    logic [4:0] r1;
    logic [4:0] r2;
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 6))
      0: return {12'h000, r1, 3'b010, rd, 7'b0000011};
      1: return {7'h00, r2, r1, 3'b000, rd, 7'b0110011};
      2: return {12'h005, r1, 3'b000, rd, 7'b0010011};
      3: return {7'h00, r2, r1, 3'b010, 5'h00, 7'b0100011};
      4: return {7'h00, r2, r1, 3'b000, 5'h00, 7'b1100011};
      5: return {20'h00001, rd, 7'b0110111};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    @(negedge clk);
    reset_cycle(32'h00500093);
    repeat (4) cycle(32'h00500093, 1'b0, 1'b0);
    check_eq("latency_s5", inst_s5, 32'h00500093);

    cycle(32'h0000A283, 1'b0, 1'b0);
    cycle(32'h00228333, 1'b0, 1'b0);
    repeat (4) cycle(NOP, 1'b0, 1'b0);
    check_eq("one_bubble_cnt", 32'(stall_cnt), 32'd1);

    cycle(32'h0000A003, 1'b0, 1'b0);
    cycle(32'h00200333, 1'b0, 1'b0);
    cycle(32'h0000A283, 1'b0, 1'b0);
    cycle(32'h00000337, 1'b0, 1'b0);
    repeat (3) cycle(NOP, 1'b0, 1'b0);
    check_eq("no_stall_cnt", 32'(stall_cnt), 32'd1);

    cycle(32'h0000A283, 1'b0, 1'b0);
    cycle(32'h00228333, 1'b0, 1'b0);
    cycle(NOP, 1'b1, 1'b0);
    cycle(32'h00100093, 1'b0, 1'b1);
    cycle(32'h00100093, 1'b0, 1'b1);
    cycle(32'h00100093, 1'b0, 1'b1);
    repeat (4) cycle(32'h00100093, 1'b0, 1'b0);
    check_eq("flush_wins_stall", 32'(stall_cnt), 32'd1);
    check_eq("flush_once", 32'(flush_cnt), 32'd1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) reset_cycle(rand_inst());
      else cycle(rand_inst(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_pipe.md
Name: riscv_hazard_pipe

Overview:
Instruction-tracking pipeline for the 5-stage RISC-V core, upstream of the forwarding unit.
- Shifts the fetched instruction word through ID/EX/MEM/WB registers (inst_s2..inst_s5); the forwarding unit consumes those registers directly.
- Detects load-use hazards and inserts EX bubbles.
- Applies branch flushes and global memory freezes.
- Keeps stall and flush performance counters.

Parameters:
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0).
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- inst_s1  input  32  instruction word from IF.
- flush  input  1  branch/jump taken, resolved in EX.
- mem_stall  input  1  data memory not ready; freezes whole pipeline.
- inst_s2  output  32  ID-stage instruction.
- inst_s3  output  32  EX-stage instruction.
- inst_s4  output  32  MEM-stage instruction.
- inst_s5  output  32  WB-stage instruction.
- pc_we  output  1  PC / IF-ID register write enable.
- load_use_stall  output  1  combinational load-use hazard indication.
- stall_cnt  output  CNT_W  cycles lost to load-use bubbles.
- flush_cnt  output  CNT_W  flush events applied.

Behaviour:
Opcodes:
- R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- Fields: rd = [11:7], rs1 = [19:15], rs2 = [24:20].

Reset (rst_n low, asynchronous):
- inst_s2..inst_s5 = NOP_INST.
- stall_cnt = 0, flush_cnt = 0.
- pc_we reflects the combinational equations below, i.e. 1 while in reset.

Source usage by inst_s2:
- uses_rs1 when opcode is R, I, LOAD, STORE or BRANCH.
- uses_rs2 when opcode is R, STORE or BRANCH.

Load-use hazard (combinational):
- load_use_stall = inst_s3 opcode is LOAD, and inst_s3.rd != 0, and ((uses_rs1 and rd == inst_s2.rs1) or (uses_rs2 and rd == inst_s2.rs2)).

Priority per clock edge, highest first:
1. mem_stall = 1: all four stage registers hold; counters hold.
2. flush = 1: inst_s2 <= NOP, inst_s3 <= NOP, inst_s4 <= inst_s3, inst_s5 <= inst_s4; flush_cnt += 1. Any coincident load_use_stall is discarded and stall_cnt does not increment.
3. load_use_stall = 1: inst_s2 holds, inst_s3 <= NOP, inst_s4 <= inst_s3, inst_s5 <= inst_s4; stall_cnt += 1.
4. Otherwise, normal shift: inst_s2 <= inst_s1, inst_s3 <= inst_s2, inst_s4 <= inst_s3, inst_s5 <= inst_s4.

Other rules:
- pc_we = ~mem_stall & (flush | ~load_use_stall). It is combinational; on flush the PC loads the branch target.
- Counters saturate at all-ones; they do not wrap.
- Latency: an instruction accepted at inst_s1 appears on inst_s5 exactly 4 unstalled edges later.
- A load followed by a dependent instruction costs exactly 1 bubble. Afterwards the load sits in s4 and the forwarding unit supplies the data.
- Hazard detection ignores the x0 destination.
- Unknown opcodes in s2 never stall.
- Reset asserted mid-stall or mid-flush clears the pipeline to NOPs immediately; no pending state survives reset.

Decomposition:
- Shared package/header riscv_defines:
  - opcode constants OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH;
  - NOP encoding;
  - field bit positions for rd, rs1, rs2.
  - The forwarding unit uses the same constants.
- One sub-module, riscv_hazard_detect: the combinational load-use compare (inputs inst_s2, inst_s3; output load_use_stall). The parent holds the stage registers, priority logic and counters.

Test Plan:
- Reset: hold rst_n=0 with inst_s1=32'h00500093 -> inst_s2..s5 = 32'h00000013, counters 0, pc_we=1; release reset and drive 4 edges -> inst_s5 = 32'h00500093.
- Load-use: lw x5,0(x1) (32'h0000A283) then add x6,x5,x2 (32'h00228333) -> load_use_stall=1 for exactly one cycle while the lw is in s3, pc_we=0, next inst_s3=NOP, inst_s2 still 32'h00228333; stall_cnt=1.
- x0 / non-user cases: lw x0,0(x1) followed by add x6,x0,x2 -> no stall. lw x5 followed by lui x6 -> no stall. Both leave stall_cnt unchanged.
- Flush: assert flush for 1 cycle with instructions A,B in s2/s3 -> next cycle inst_s2=inst_s3=NOP, inst_s4=B; flush_cnt=1. Flush coincident with a load-use hazard -> flush wins, stall_cnt unchanged.
- mem_stall: assert for 3 cycles mid-stream -> all stage registers and counters frozen, pc_we=0; the stream resumes unchanged afterwards.
- Saturation: with CNT_W=2, create 5 load-use bubbles -> stall_cnt = 2'b11.
